// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier with a fixed WIDTH-cycle latency.
// Accepts start/a/b in IDLE, runs WIDTH iterations, then pulses done for one cycle.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    // acc is left untouched outside RUN so the result holds until the next accept
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=8): reset, products, busy start,
// mid-run reset and continuous start, all with hand-computed expectations.
module tb_seq_multiplier;

    localparam int W = 8;

    logic             clk;
    logic             rst_l;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             ready;
    logic             done;
    logic [2*W-1:0]   product;

    int passed;
    int total;
    int edges;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Bounded wait: counts edges until done rises, giving up after 20
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] exp);
        int n;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_ready_after_accept"}, 32'(ready), 32'd0);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_product"}, 32'(product), 32'(exp));
        check({tag, "_ready_in_done"}, 32'(ready), 32'd0);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_ready_back"}, 32'(ready), 32'd1);
        check({tag, "_product_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_l  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        // Reset then idle
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'h0000);
        rst_l = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_done", 32'(done), 32'd0);
            check("idle_product", 32'(product), 32'h0000);
        end

        // Basic and extreme products
        run_op("m13x11", 8'd13, 8'd11, 16'h008F);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_8f", 32'(product), 32'h008F);
        end
        run_op("m255x255", 8'd255, 8'd255, 16'hFE01);
        run_op("m0x200", 8'd0, 8'd200, 16'h0000);
        run_op("m1x128", 8'd1, 8'd128, 16'h0080);

        // Start while busy is ignored
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'd7;
        b = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_ready", 32'(ready), 32'd0);
        wait_done(edges);
        check("busy_latency", 32'(edges), 32'd5);
        check("busy_product", 32'(product), 32'h000F);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("busy_no_second_done", 32'(done), 32'd0);
            check("busy_hold", 32'(product), 32'h000F);
        end

        // Reset mid-operation
        a = 8'd200;
        b = 8'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_product", 32'(product), 32'h0000);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_no_done", 32'(done), 32'd0);
        end

        // Continuous start: done every 10 cycles, ready for one cycle between ops
        a = 8'd6;
        b = 8'd7;
        start = 1'b1;
        tick();
        check("cont_accept", 32'(ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_done(edges);
            check("cont_latency", 32'(edges), 32'd8);
            check("cont_product", 32'(product), 32'h002A);
            tick();
            check("cont_idle_ready", 32'(ready), 32'd1);
            check("cont_idle_done", 32'(done), 32'd0);
            tick();
            check("cont_reaccept", 32'(ready), 32'd0);
            check("cont_run_done", 32'(done), 32'd0);
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
